// File: rtl/conv_4_gray.sv
// conv_4_gray: registered 4-bit binary-to-Gray converter.
// The Gray code is produced by three independent realizations (behavioral,
// dataflow, structural). They are compared on every accepted cycle; any
// disagreement sets a sticky mismatch flag and bumps a saturating counter.
// gray_out is always loaded from the behavioral realization.
module conv_4_gray (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] bin_in,
   input  logic       in_valid,
   output logic [3:0] gray_out,
   output logic       out_valid,
   output logic       mismatch,
   output logic [7:0] err_count
);

   // Three combinational realizations of the same conversion
   logic [3:0] gray_beh_s;
   logic [3:0] gray_df_s;
   wire  [3:0] gray_st_s;

   // Disagreement between realizations on the current operand
   logic       disagree_s;

   // Registered state and next-state values
   logic [3:0] gray_q;
   logic [3:0] gray_d;
   logic       valid_q;
   logic       valid_d;
   logic       mismatch_q;
   logic       mismatch_d;
   logic [7:0] err_q;
   logic [7:0] err_d;

   // Behavioral realization: each Gray bit computed procedurally
   always_comb begin
      gray_beh_s    = 4'b0000;
      gray_beh_s[3] = bin_in[3];
      gray_beh_s[2] = bin_in[3] ^ bin_in[2];
      gray_beh_s[1] = bin_in[2] ^ bin_in[1];
      gray_beh_s[0] = bin_in[1] ^ bin_in[0];
   end

   // Dataflow realization: XOR of the operand with itself shifted right by one
   assign gray_df_s = bin_in ^ (bin_in >> 1);

   // Structural realization: gate primitives, buffer on the MSB
   buf u_buf_g3 (gray_st_s[3], bin_in[3]);
   xor u_xor_g2 (gray_st_s[2], bin_in[3], bin_in[2]);
   xor u_xor_g1 (gray_st_s[1], bin_in[2], bin_in[1]);
   xor u_xor_g0 (gray_st_s[0], bin_in[1], bin_in[0]);

   // Cross-check: 4-state inequality so an X/Z on any path also counts as a fault
   always_comb begin
      disagree_s = 1'b0;
      if ((gray_beh_s !== gray_df_s) || (gray_beh_s !== gray_st_s)) begin
         disagree_s = 1'b1;
      end else begin
         disagree_s = 1'b0;
      end
   end

   // Next-state: load on accepted input, hold otherwise; counter saturates at 255
   always_comb begin
      gray_d     = gray_q;
      valid_d    = in_valid;
      mismatch_d = mismatch_q;
      err_d      = err_q;
      if (in_valid) begin
         gray_d = gray_beh_s;
         if (disagree_s) begin
            mismatch_d = 1'b1;
            if (err_q != 8'd255) begin
               err_d = err_q + 8'd1;
            end else begin
               err_d = err_q;
            end
         end else begin
            mismatch_d = mismatch_q;
            err_d      = err_q;
         end
      end else begin
         gray_d     = gray_q;
         mismatch_d = mismatch_q;
         err_d      = err_q;
      end
   end

   // State registers with synchronous reset that overrides any valid input
   always_ff @(posedge clk) begin
      if (rst) begin
         gray_q     <= 4'b0000;
         valid_q    <= 1'b0;
         mismatch_q <= 1'b0;
         err_q      <= 8'd0;
      end else begin
         gray_q     <= gray_d;
         valid_q    <= valid_d;
         mismatch_q <= mismatch_d;
         err_q      <= err_d;
      end
   end

   assign gray_out  = gray_q;
   assign out_valid = valid_q;
   assign mismatch  = mismatch_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_conv_4_gray.sv
// Directed, table-driven bench for conv_4_gray with hand-computed expectations,
// plus a forced-fault sequence for the internal cross-check.
module tb_conv_4_gray;

   logic       clk;
   logic       rst;
   logic [3:0] bin_in;
   logic       in_valid;
   logic [3:0] gray_out;
   logic       out_valid;
   logic       mismatch;
   logic [7:0] err_count;

   int errors;
   int checks;

   conv_4_gray dut (
      .clk       (clk),
      .rst       (rst),
      .bin_in    (bin_in),
      .in_valid  (in_valid),
      .gray_out  (gray_out),
      .out_valid (out_valid),
      .mismatch  (mismatch),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       valid;
      logic [3:0] bin;
      logic [3:0] exp_gray;
      logic       exp_valid;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive inputs on the falling edge, then sample just after the rising edge
   task automatic step(input logic r, input logic v, input logic [3:0] b);
      @(negedge clk);
      rst      = r;
      in_valid = v;
      bin_in   = b;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic r, input logic v, input logic [3:0] b,
                      input logic [3:0] eg, input logic ev);
      vec_t t;
      t.rst = r; t.valid = v; t.bin = b; t.exp_gray = eg; t.exp_valid = ev;
      vecs.push_back(t);
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      rst      = 1'b1;
      in_valid = 1'b1;
      bin_in   = 4'b1111;

      // Reset with a valid input present: discarded
      add(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
      add(1'b1, 1'b1, 4'hF, 4'h0, 1'b0);
      // Exhaustive sweep
      add(1'b0, 1'b1, 4'h0, 4'h0, 1'b1);
      add(1'b0, 1'b1, 4'h1, 4'h1, 1'b1);
      add(1'b0, 1'b1, 4'h2, 4'h3, 1'b1);
      add(1'b0, 1'b1, 4'h3, 4'h2, 1'b1);
      add(1'b0, 1'b1, 4'h4, 4'h6, 1'b1);
      add(1'b0, 1'b1, 4'h5, 4'h7, 1'b1);
      add(1'b0, 1'b1, 4'h6, 4'h5, 1'b1);
      add(1'b0, 1'b1, 4'h7, 4'h4, 1'b1);
      add(1'b0, 1'b1, 4'h8, 4'hC, 1'b1);
      add(1'b0, 1'b1, 4'h9, 4'hD, 1'b1);
      add(1'b0, 1'b1, 4'hA, 4'hF, 1'b1);
      add(1'b0, 1'b1, 4'hB, 4'hE, 1'b1);
      add(1'b0, 1'b1, 4'hC, 4'hA, 1'b1);
      add(1'b0, 1'b1, 4'hD, 4'hB, 1'b1);
      add(1'b0, 1'b1, 4'hE, 4'h9, 1'b1);
      add(1'b0, 1'b1, 4'hF, 4'h8, 1'b1);
      // Hold while in_valid is low
      add(1'b0, 1'b1, 4'h6, 4'h5, 1'b1);
      add(1'b0, 1'b0, 4'h9, 4'h5, 1'b0);
      add(1'b0, 1'b0, 4'h9, 4'h5, 1'b0);
      add(1'b0, 1'b0, 4'h9, 4'h5, 1'b0);
      // Back-to-back versus gapped
      add(1'b0, 1'b1, 4'h3, 4'h2, 1'b1);
      add(1'b0, 1'b0, 4'h3, 4'h2, 1'b0);
      add(1'b0, 1'b1, 4'h4, 4'h6, 1'b1);
      add(1'b0, 1'b1, 4'h7, 4'h4, 1'b1);
      // Mid-stream reset at 1000, then resume with 1000
      add(1'b0, 1'b1, 4'h6, 4'h5, 1'b1);
      add(1'b0, 1'b1, 4'h7, 4'h4, 1'b1);
      add(1'b1, 1'b1, 4'h8, 4'h0, 1'b0);
      add(1'b0, 1'b1, 4'h8, 4'hC, 1'b1);
      add(1'b0, 1'b1, 4'h9, 4'hD, 1'b1);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].rst, vecs[i].valid, vecs[i].bin);
         check($sformatf("vec%0d gray_out", i), {4'h0, gray_out}, {4'h0, vecs[i].exp_gray});
         check($sformatf("vec%0d out_valid", i), {7'h0, out_valid}, {7'h0, vecs[i].exp_valid});
         check($sformatf("vec%0d mismatch", i), {7'h0, mismatch}, 8'h00);
         check($sformatf("vec%0d err_count", i), err_count, 8'h00);
      end

      // Cross-check: corrupt bit 0 of the dataflow path (0101 -> 0111 becomes 0110)
      force dut.gray_df_s = 4'b0110;
      for (int c = 1; c <= 300; c++) begin
         step(1'b0, 1'b1, 4'h5);
         if (c == 1) begin
            check("fault first mismatch", {7'h0, mismatch}, 8'h01);
            check("fault first err_count", err_count, 8'd1);
         end
         if (c == 254) check("fault err_count 254", err_count, 8'd254);
         if (c == 255) check("fault err_count 255", err_count, 8'd255);
         if (c == 300) begin
            check("fault err_count saturated", err_count, 8'd255);
            check("fault gray_out behavioral", {4'h0, gray_out}, 8'h07);
            check("fault out_valid", {7'h0, out_valid}, 8'h01);
         end
      end
      release dut.gray_df_s;

      // Sticky flags hold with in_valid low and with clean inputs afterwards
      step(1'b0, 1'b0, 4'h2);
      check("sticky mismatch idle", {7'h0, mismatch}, 8'h01);
      check("sticky err_count idle", err_count, 8'd255);
      step(1'b0, 1'b1, 4'h2);
      check("sticky mismatch clean", {7'h0, mismatch}, 8'h01);
      check("clean gray_out", {4'h0, gray_out}, 8'h03);

      // Only reset clears them
      step(1'b1, 1'b0, 4'h2);
      check("rst mismatch cleared", {7'h0, mismatch}, 8'h00);
      check("rst err_count cleared", err_count, 8'h00);
      check("rst gray_out cleared", {4'h0, gray_out}, 8'h00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
